uart_frame_receiver: RTL

Serial-to-parallel UART receiver that the UART peripheral instantiates on its receive side. It detects start bits on Rxd and samples each bit at its centre, using a baud counter driven by the peripheral's parameter registers. Per frame it delivers the data byte and parity/frame error indications as single-cycle pulses. These pulses feed the DR, SR and ISR write logic of the peripheral.

---
 rtl/uart_frame_receiver.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_receiver.sv
// UART receive path: synchronises Rxd, finds start bits, samples each bit at its centre
// and reports each frame as a one-cycle data-ready or error pulse.
module uart_frame_receiver #(
   parameter int BAUD_WIDTH  = 14,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_enable,
   input  logic                  i_rxd,
   input  logic [2:0]            i_data_len_limit,
   input  logic                  i_stop_len_limit,
   input  logic                  i_parity_en,
   input  logic                  i_parity_polarity,
   input  logic [BAUD_WIDTH-1:0] i_baud_limit,
   output logic [7:0]            o_rx_data,
   output logic                  o_rx_ready,
   output logic                  o_rx_parity_err,
   output logic                  o_rx_frame_err,
   output logic                  o_rx_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t                r_state;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                  r_rxd_d;
   logic [BAUD_WIDTH-1:0] r_baud_cnt;
   logic [BAUD_WIDTH-1:0] r_baud_lim;
   logic [2:0]            r_len_lim;
   logic                  r_stop_lim;
   logic                  r_par_en;
   logic                  r_par_pol;
   logic [2:0]            r_bit_idx;
   logic                  r_stop_idx;
   logic [7:0]            r_shift;
   logic                  r_par_flag;
   logic                  r_frame_flag;

   logic                  w_rxd_s;
   logic                  w_fall;
   logic                  w_tick;
   logic                  w_half;
   logic                  w_stop_bad;
   logic                  w_par_exp;
   logic [BAUD_WIDTH-1:0] w_cnt_inc;

   // Synchroniser stages idle high so reset never looks like a start edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync  <= '1;
         r_rxd_d <= 1'b1;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], i_rxd};
         r_rxd_d <= w_rxd_s;
      end
   end

   assign w_rxd_s    = r_sync[SYNC_STAGES-1];
   assign w_fall     = r_rxd_d & ~w_rxd_s;
   assign w_tick     = (r_baud_cnt == r_baud_lim);
   assign w_half     = (r_baud_cnt == (r_baud_lim >> 1));
   assign w_cnt_inc  = r_baud_cnt + BAUD_WIDTH'(1);
   assign w_stop_bad = r_frame_flag | ~w_rxd_s;
   // Unused upper shift bits stay cleared, so this covers only the received data bits.
   assign w_par_exp  = (^r_shift) ^ r_par_pol;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state         <= S_IDLE;
         r_baud_cnt      <= '0;
         r_baud_lim      <= '0;
         r_len_lim       <= '0;
         r_stop_lim      <= 1'b0;
         r_par_en        <= 1'b0;
         r_par_pol       <= 1'b0;
         r_bit_idx       <= '0;
         r_stop_idx      <= 1'b0;
         r_shift         <= '0;
         r_par_flag      <= 1'b0;
         r_frame_flag    <= 1'b0;
         o_rx_data       <= '0;
         o_rx_ready      <= 1'b0;
         o_rx_parity_err <= 1'b0;
         o_rx_frame_err  <= 1'b0;
         o_rx_busy       <= 1'b0;
      end else begin
         o_rx_ready      <= 1'b0;
         o_rx_parity_err <= 1'b0;
         o_rx_frame_err  <= 1'b0;
         if (!i_enable) begin
            r_state   <= S_IDLE;
            o_rx_busy <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_fall) begin
                     r_state      <= S_START;
                     r_baud_cnt   <= '0;
                     o_rx_busy    <= 1'b1;
                     r_baud_lim   <= i_baud_limit;
                     r_len_lim    <= i_data_len_limit;
                     r_stop_lim   <= i_stop_len_limit;
                     r_par_en     <= i_parity_en;
                     r_par_pol    <= i_parity_polarity;
                     r_bit_idx    <= '0;
                     r_stop_idx   <= 1'b0;
                     r_shift      <= '0;
                     r_par_flag   <= 1'b0;
                     r_frame_flag <= 1'b0;
                  end
               end
               S_START: begin
                  if (w_half) begin
                     if (w_rxd_s) begin
                        r_state   <= S_IDLE;
                        o_rx_busy <= 1'b0;
                     end else begin
                        r_baud_cnt <= '0;
                        r_state    <= S_DATA;
                     end
                  end else begin
                     r_baud_cnt <= w_cnt_inc;
                  end
               end
               S_DATA: begin
                  if (w_tick) begin
                     r_baud_cnt         <= '0;
                     r_shift[r_bit_idx] <= w_rxd_s;
                     if (r_bit_idx == r_len_lim) begin
                        r_state <= r_par_en ? S_PARITY : S_STOP;
                     end else begin
                        r_bit_idx <= r_bit_idx + 3'd1;
                     end
                  end else begin
                     r_baud_cnt <= w_cnt_inc;
                  end
               end
               S_PARITY: begin
                  if (w_tick) begin
                     r_baud_cnt <= '0;
                     r_par_flag <= (w_rxd_s != w_par_exp);
                     r_state    <= S_STOP;
                  end else begin
                     r_baud_cnt <= w_cnt_inc;
                  end
               end
               S_STOP: begin
                  if (w_tick) begin
                     r_baud_cnt   <= '0;
                     r_frame_flag <= w_stop_bad;
                     if (r_stop_idx == r_stop_lim) begin
                        // Finish at the centre of the last stop bit to allow back-to-back frames.
                        o_rx_busy <= 1'b0;
                        if (!w_stop_bad && !r_par_flag) begin
                           o_rx_data  <= r_shift;
                           o_rx_ready <= 1'b1;
                           r_state    <= S_IDLE;
                        end else begin
                           o_rx_parity_err <= r_par_flag;
                           o_rx_frame_err  <= w_stop_bad;
                           r_state         <= w_rxd_s ? S_IDLE : S_WAIT_HIGH;
                        end
                     end else begin
                        r_stop_idx <= 1'b1;
                     end
                  end else begin
                     r_baud_cnt <= w_cnt_inc;
                  end
               end
               S_WAIT_HIGH: begin
                  if (w_rxd_s) begin
                     r_state <= S_IDLE;
                  end
               end
               default: begin
                  r_state   <= S_IDLE;
                  o_rx_busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
